// File: rtl/adc_packetizer.sv
// adc_packetizer: frames multi-channel ADC samples into an 8-bit AXI-S packet stream
// Ports:
//   i_clk, i_rst_n                    clock, asynchronous active-low reset
//   i_s_axis_tdata/ts/tvalid          wide sample word + timestamp in
//   o_s_axis_tready                   input ready (IDLE, or NEXT with no flush pending)
//   i_chn_en, i_pkt_len, i_ts_en,     per-packet config, latched at packet start
//   i_fmt_signed
//   i_flush                           pulse: close the open packet early
//   o_m_axis_tdata/tvalid/tlast       byte stream out, i_m_axis_tready backpressure
//   o_busy                            a packet is open
module adc_packetizer #(
  parameter int NUM_CHANNELS = 4,
  parameter int CHN_WIDTH = 14,
  parameter int CHN_BYTES = (CHN_WIDTH + 7) / 8,
  parameter int TS_WIDTH = 32,
  parameter int TS_BYTES = (TS_WIDTH + 7) / 8,
  parameter int PKT_LEN_WIDTH = 8,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic [NUM_CHANNELS*CHN_WIDTH-1:0] i_s_axis_tdata,
  input  logic [TS_WIDTH-1:0]               i_s_axis_ts,
  input  logic                              i_s_axis_tvalid,
  output logic                              o_s_axis_tready,
  input  logic [NUM_CHANNELS-1:0]           i_chn_en,
  input  logic [PKT_LEN_WIDTH-1:0]          i_pkt_len,
  input  logic                              i_ts_en,
  input  logic                              i_fmt_signed,
  input  logic                              i_flush,
  output logic [7:0]                        o_m_axis_tdata,
  output logic                              o_m_axis_tvalid,
  input  logic                              i_m_axis_tready,
  output logic                              o_m_axis_tlast,
  output logic                              o_busy
);
  localparam int CB8 = CHN_BYTES * 8;
  localparam int TB8 = TS_BYTES * 8;
  localparam int SW = NUM_CHANNELS * CHN_WIDTH;
  typedef enum logic [2:0] {IDLE, HDR, TS, DATA, NEXT, TRL} state_t;
  state_t                   r_state;
  logic [7:0]               r_seq, r_idx;
  logic [PKT_LEN_WIDTH-1:0] r_cnt, r_len;
  logic [NUM_CHANNELS-1:0]  r_mask;
  logic [SW-1:0]            r_sample;
  logic [TS_WIDTH-1:0]      r_ts;
  logic                     r_ts_en, r_fmt, r_flush;
  logic [3:0]               r_ch;
  logic [3:0]               w_first, w_next;
  logic [CB8-1:0]           w_chn;
  logic [TB8-1:0]           w_ts;
  logic [PKT_LEN_WIDTH:0]   w_cnt1;
  logic                     w_xfer;
  // signed format: offset-binary to two's complement by flipping each channel MSB
  function automatic logic [SW-1:0] fmt(input logic [SW-1:0] d, input logic s);
    fmt = d;
    for (int i = 0; i < NUM_CHANNELS; i++) fmt[(i+1)*CHN_WIDTH-1] = d[(i+1)*CHN_WIDTH-1] ^ s;
  endfunction
  // lowest enabled channel at or above 'from'; NUM_CHANNELS means none left
  function automatic logic [3:0] next_ch(input logic [NUM_CHANNELS-1:0] m, input int from);
    next_ch = 4'(NUM_CHANNELS);
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) if (m[i] && i >= from) next_ch = 4'(i);
  endfunction
  assign w_first = next_ch(r_mask, 0);
  assign w_next = next_ch(r_mask, int'(r_ch) + 1);
  assign w_chn = CB8'(r_sample[int'(r_ch)*CHN_WIDTH +: CHN_WIDTH]) << (CB8 - CHN_WIDTH);
  assign w_ts = TB8'(r_ts);
  assign w_cnt1 = (PKT_LEN_WIDTH+1)'(r_cnt) + (PKT_LEN_WIDTH+1)'(1);
  assign w_xfer = o_m_axis_tvalid && i_m_axis_tready;
  // a pending flush wins over a NEXT-state handshake, so refuse the sample
  assign o_s_axis_tready = r_state == IDLE || (r_state == NEXT && !r_flush);
  assign o_m_axis_tvalid = r_state inside {HDR, TS, DATA, TRL};
  assign o_m_axis_tlast = r_state == TRL;
  assign o_busy = r_state != IDLE;
  assign o_m_axis_tdata =
    r_state == HDR  ? (r_idx == 8'd0 ? SYNC_BYTE : r_idx == 8'd1 ? r_seq :
                       r_idx == 8'd2 ? 8'(r_mask) : {6'b0, r_fmt, r_ts_en}) :
    r_state == TS   ? w_ts[r_idx*8 +: 8] :
    r_state == DATA ? w_chn[r_idx*8 +: 8] :
    r_state == TRL  ? 8'(w_cnt1) : 8'h00;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_seq <= '0;
      r_idx <= '0;
      r_cnt <= '0;
      r_len <= '0;
      r_mask <= '0;
      r_sample <= '0;
      r_ts <= '0;
      r_ts_en <= 1'b0;
      r_fmt <= 1'b0;
      r_flush <= 1'b0;
      r_ch <= '0;
    end else begin
      if (i_flush && r_state != IDLE) r_flush <= 1'b1;
      case (r_state)
        IDLE: if (i_s_axis_tvalid && |i_chn_en) begin
          r_sample <= fmt(i_s_axis_tdata, i_fmt_signed);
          r_ts <= i_s_axis_ts;
          r_mask <= i_chn_en;
          r_len <= i_pkt_len;
          r_ts_en <= i_ts_en;
          r_fmt <= i_fmt_signed;
          r_cnt <= '0;
          r_idx <= '0;
          r_state <= HDR;
        end
        HDR: if (w_xfer) begin
          if (r_idx == 8'd3) begin
            r_idx <= '0;
            r_ch <= w_first;
            r_state <= r_ts_en ? TS : DATA;
          end else r_idx <= r_idx + 8'd1;
        end
        TS: if (w_xfer) begin
          if (r_idx == 8'(TS_BYTES - 1)) begin
            r_idx <= '0;
            r_state <= DATA;
          end else r_idx <= r_idx + 8'd1;
        end
        DATA: if (w_xfer) begin
          if (r_idx == 8'(CHN_BYTES - 1)) begin
            r_idx <= '0;
            if (w_next == 4'(NUM_CHANNELS)) r_state <= (r_cnt == r_len || r_flush) ? TRL : NEXT;
            else r_ch <= w_next;
          end else r_idx <= r_idx + 8'd1;
        end
        NEXT: if (r_flush) r_state <= TRL;
          else if (i_s_axis_tvalid) begin
            r_sample <= fmt(i_s_axis_tdata, r_fmt);
            r_cnt <= r_cnt + PKT_LEN_WIDTH'(1);
            r_ch <= w_first;
            r_state <= DATA;
          end
        TRL: if (w_xfer) begin
          r_seq <= r_seq + 8'd1;
          r_flush <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adc_packetizer.sv
// tb_adc_packetizer: directed checks of packet framing, backpressure, flush, seq wrap and reset
module tb_adc_packetizer;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic [55:0] s_data = '0;
  logic [31:0] s_ts = '0;
  logic s_valid = 0, s_ready;
  logic [3:0] chn_en = '0;
  logic [7:0] pkt_len = '0;
  logic ts_en = 0, fmt_s = 0, flush = 0;
  logic [7:0] m_data;
  logic m_valid, m_last, busy;
  logic m_ready = 1'b1, bp_en = 1'b0;
  int errs = 0, checks = 0;
  logic [8:0] q[$], e[$], e1[$];
  logic stall = 0, rdy_bad = 0;
  logic [8:0] pv = '0;
  adc_packetizer dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_s_axis_tdata(s_data), .i_s_axis_ts(s_ts), .i_s_axis_tvalid(s_valid), .o_s_axis_tready(s_ready),
    .i_chn_en(chn_en), .i_pkt_len(pkt_len), .i_ts_en(ts_en), .i_fmt_signed(fmt_s), .i_flush(flush),
    .o_m_axis_tdata(m_data), .o_m_axis_tvalid(m_valid), .i_m_axis_tready(m_ready),
    .o_m_axis_tlast(m_last), .o_busy(busy)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [55:0] pk(input logic [13:0] a, b, c, d);
    return {d, c, b, a};
  endfunction
  always @(posedge clk) begin
    #1;
    m_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  always @(negedge clk) begin
    if (m_valid && m_ready) q.push_back({m_last, m_data});
    if (stall && rst_n) begin
      chk("bp_hold_valid", 32'(m_valid), 1);
      chk("bp_hold_data", 32'({m_last, m_data}), 32'(pv));
    end
    stall = m_valid && !m_ready && rst_n;
    pv = {m_last, m_data};
    if (s_ready && m_valid) rdy_bad = 1;
  end
  task automatic send(input logic [55:0] d, input logic [31:0] t);
    s_data = d;
    s_ts = t;
    s_valid = 1;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (s_ready) break;
    end
    if (!s_ready) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1 s_valid = 0;
  endtask
  task automatic wait_idle();
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (busy) chk("idle_timeout", 1, 0);
    @(posedge clk);
    #1;
  endtask
  task automatic do_rst();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask
  task automatic cmp(input string nm, input logic [8:0] x[$]);
    chk({nm, "_len"}, q.size(), x.size());
    for (int i = 0; i < x.size() && i < q.size(); i++) chk($sformatf("%s_b%0d", nm, i), 32'(q[i]), 32'(x[i]));
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    #12;
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_last", 32'(m_last), 0);
    chk("rst_data", 32'(m_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(s_ready), 1);
    @(posedge clk);
    #1 rst_n = 1;
    e1 = '{9'h0A5, 9'h000, 9'h00F, 9'h001, 9'h078, 9'h056, 9'h034, 9'h012};
    for (int i = 0; i < 4; i++) begin e1.push_back(9'h0FC); e1.push_back(9'h0FF); end
    for (int i = 0; i < 4; i++) begin e1.push_back(9'h004); e1.push_back(9'h000); end
    e1.push_back(9'h102);
    chn_en = 4'hF; pkt_len = 1; ts_en = 1; fmt_s = 0;
    q.delete();
    send(pk(14'h3FFF, 14'h3FFF, 14'h3FFF, 14'h3FFF), 32'h12345678);
    chk("t1_lat_valid", 32'(m_valid), 1);
    chk("t1_lat_data", 32'(m_data), 32'hA5);
    send(pk(14'h1, 14'h1, 14'h1, 14'h1), 32'h0);
    wait_idle();
    cmp("t1", e1);
    do_rst();
    chn_en = 4'b0101; pkt_len = 0; ts_en = 0; fmt_s = 1;
    q.delete();
    send(pk(14'h2000, 14'h1234, 14'h0000, 14'h3FFF), 32'h0);
    wait_idle();
    e = '{9'h0A5, 9'h000, 9'h005, 9'h002, 9'h000, 9'h000, 9'h000, 9'h080, 9'h101};
    cmp("t2", e);
    do_rst();
    chn_en = 4'hF; pkt_len = 1; ts_en = 1; fmt_s = 0;
    q.delete();
    rdy_bad = 0;
    bp_en = 1;
    send(pk(14'h3FFF, 14'h3FFF, 14'h3FFF, 14'h3FFF), 32'h12345678);
    send(pk(14'h1, 14'h1, 14'h1, 14'h1), 32'h0);
    wait_idle();
    bp_en = 0;
    cmp("t3", e1);
    chk("t3_rdy_excl", 32'(rdy_bad), 0);
    do_rst();
    chn_en = 4'b0001; pkt_len = 9; ts_en = 0; fmt_s = 0;
    q.delete();
    send(pk(14'h1, 0, 0, 0), 0);
    send(pk(14'h2, 0, 0, 0), 0);
    send(pk(14'h3, 0, 0, 0), 0);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (s_ready && busy) break;
    end
    chk("t4_in_next", 32'(s_ready && busy), 1);
    @(posedge clk);
    #1 flush = 1;
    @(posedge clk);
    #1 flush = 0;
    wait_idle();
    e = '{9'h0A5, 9'h000, 9'h001, 9'h000, 9'h004, 9'h000, 9'h008, 9'h000, 9'h00C, 9'h000, 9'h103};
    cmp("t4", e);
    flush = 1;
    @(posedge clk);
    #1 flush = 0;
    pkt_len = 1;
    q.delete();
    send(pk(14'h5, 0, 0, 0), 0);
    send(pk(14'h6, 0, 0, 0), 0);
    wait_idle();
    e = '{9'h0A5, 9'h001, 9'h001, 9'h000, 9'h014, 9'h000, 9'h018, 9'h000, 9'h102};
    cmp("t4b", e);
    do_rst();
    chn_en = 4'b0000; pkt_len = 0; ts_en = 0;
    q.delete();
    for (int i = 0; i < 5; i++) send(pk(14'(i), 0, 0, 0), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_no_bytes", q.size(), 0);
    chn_en = 4'b0001;
    for (int k = 0; k <= 256; k++) begin
      q.delete();
      send(pk(14'h7, 0, 0, 0), 0);
      wait_idle();
      chk($sformatf("t5_seq%0d", k), q.size() > 1 ? 32'(q[1]) : 32'h1FF, 32'(k & 255));
    end
    q.delete();
    pkt_len = 8'hFF;
    for (int i = 0; i < 256; i++) send(pk(14'(i), 0, 0, 0), 0);
    wait_idle();
    chk("t5_len256", q.size(), 517);
    chk("t5_trl256", q.size() > 0 ? 32'(q[$]) : 32'h0, 32'h100);
    do_rst();
    chn_en = 4'hF; ts_en = 1; pkt_len = 0;
    send(pk(14'h11, 14'h22, 14'h33, 14'h44), 32'hCAFE);
    repeat (9) @(posedge clk);
    #1;
    chk("t6_pre_valid", 32'(m_valid), 1);
    s_valid = 1;
    rst_n = 0;
    #1;
    chk("t6_valid", 32'(m_valid), 0);
    chk("t6_last", 32'(m_last), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_data", 32'(m_data), 0);
    repeat (3) @(posedge clk);
    #1 s_valid = 0;
    rst_n = 1;
    chk("t6_idle", 32'(busy), 0);
    chn_en = 4'b0001; ts_en = 0;
    q.delete();
    send(pk(14'h9, 0, 0, 0), 0);
    wait_idle();
    chk("t6_b0", q.size() > 0 ? 32'(q[0]) : 32'h1FF, 32'h0A5);
    chk("t6_b1", q.size() > 1 ? 32'(q[1]) : 32'h1FF, 32'h000);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/adc_packetizer.md
# adc_packetizer

Packetizing serializer for synchronously sampled multi-channel ADC data. It replaces the fixed one-sample-per-beat serializer behind the ADC/TS FIFO. It accepts one wide sample word per beat with its timestamp and emits an 8-bit AXI-S byte stream of framed packets: header, optional timestamp, N samples and a trailer, with TLAST on the trailer. Channel count, channel width, packet length, output format and early flush are all configurable.

## Interface

**Parameters**

- `NUM_CHANNELS`, 4: number of ADC channels; must be 1..8, because the mask occupies one header byte.
- `CHN_WIDTH`, 14: raw ADC resolution in bits.
- `CHN_BYTES`, (CHN_WIDTH+7)/8: output bytes per channel.
- `TS_WIDTH`, 32: timestamp width.
- `TS_BYTES`, (TS_WIDTH+7)/8: timestamp bytes emitted.
- `PKT_LEN_WIDTH`, 8: width of the samples-per-packet setting.
- `SYNC_BYTE`, 8'hA5: first header byte.

**Ports**

- `i_clk` in 1: clock.
- `i_rst_n` in 1: reset; asynchronous, active-low.
- `i_s_axis_tdata` in NUM_CHANNELS*CHN_WIDTH: raw samples, channel i at bits [(i+1)*CHN_WIDTH-1 : i*CHN_WIDTH].
- `i_s_axis_ts` in TS_WIDTH: timestamp qualified with `i_s_axis_tvalid`.
- `i_s_axis_tvalid` in 1 / `o_s_axis_tready` out 1: input handshake.
- `i_chn_en` in NUM_CHANNELS: channel enable mask.
- `i_pkt_len` in PKT_LEN_WIDTH: samples per packet minus 1.
- `i_ts_en` in 1: include the timestamp field.
- `i_fmt_signed` in 1: convert offset-binary to two's complement by inverting the raw MSB.
- `i_flush` in 1: single-cycle pulse requesting early packet close.
- `o_m_axis_tdata` out 8, `o_m_axis_tvalid` out 1, `i_m_axis_tready` in 1, `o_m_axis_tlast` out 1: byte output.
- `o_busy` out 1: a packet is open (state ≠ IDLE).

## Operation

**States:** IDLE, HDR, TS, DATA, NEXT, TRL.

- **IDLE:** `o_s_axis_tready`=1.
  - On a handshake with `i_chn_en`≠0: latch the sample (format applied), the timestamp and the config (`i_chn_en`, `i_pkt_len`, `i_ts_en`, `i_fmt_signed`). Set sample count cnt=0 and go to HDR.
  - On a handshake with `i_chn_en`=0: discard the sample and stay in IDLE; seq is unchanged.
- **HDR:** emits 4 bytes.
  - Byte 0: SYNC_BYTE.
  - Byte 1: seq[7:0].
  - Byte 2: the latched mask, zero-extended to 8 bits.
  - Byte 3: flags. Bit 0 = ts_en, bit 1 = fmt_signed, all other bits 0.
  - Then go to TS if ts_en, else DATA.
- **TS:** emits TS_BYTES bytes, little-endian, zero-padded above TS_WIDTH.
- **DATA:** for each enabled channel in ascending index order (disabled channels skipped, no gap cycles), emit CHN_BYTES bytes little-endian.
  - The value is left-justified: {raw, (CHN_BYTES*8−CHN_WIDTH) zeros}.
  - After the final byte of the highest enabled channel:
    - if cnt==pkt_len or a flush is pending → TRL;
    - else → NEXT.
- **NEXT:** `o_s_axis_tready`=1.
  - On a handshake: latch the sample only (config and timestamp keep their packet-start values), cnt++, go to DATA.
  - If a flush is pending: go to TRL. This has priority over a same-cycle input handshake, which is therefore not accepted (tready is forced to 0 in that cycle).
- **TRL:** emits one byte = (cnt+1)[7:0] with TLAST=1.
  - On acceptance: seq++ (wraps 255→0), clear the pending flush, go to IDLE.
- **Flush:** an `i_flush` pulse sets a pending flag in any state except IDLE; in IDLE it is ignored.
- Config inputs changing mid-packet have no effect until the next packet start.

## Timing

- The input is accepted only in IDLE/NEXT.
- Latency: handshake in IDLE at cycle t → header byte 0 valid at t+1.
- Throughput: one byte per cycle while `i_m_axis_tready`=1, with no bubbles between fields.
- Packet length: 4 + ts_en·TS_BYTES + S·popcount(mask)·CHN_BYTES + 1 bytes, where S is the sample count.
- AXI-S rule: once `o_m_axis_tvalid`=1, `o_m_axis_tdata` and `o_m_axis_tlast` hold until accepted; tvalid never drops without a transfer.
- `o_m_axis_tvalid`=1 exactly in HDR/TS/DATA/TRL.
- `o_m_axis_tlast`=1 only in TRL.
- In IDLE/NEXT, `o_m_axis_tdata`=0.
- Boundary: pkt_len=2^PKT_LEN_WIDTH−1 with PKT_LEN_WIDTH=8 gives 256 samples and trailer 0x00.
- Reset (asynchronous, immediate, including mid-packet):
  - state=IDLE, seq=0, cnt=0, flush flag cleared, latched regs=0;
  - `o_m_axis_tvalid`=0, `o_m_axis_tlast`=0, `o_m_axis_tdata`=0, `o_busy`=0;
  - `o_s_axis_tready` follows state (1); handshakes while `i_rst_n`=0 are ignored.

## Test plan

1. **Full packet with timestamp.** Defaults; mask=4'hF, pkt_len=1, ts_en=1, signed=0, ts=0x12345678; sample 1 all channels=0x3FFF, sample 2 all channels=0x0001.
   - Required bytes: A5 00 0F 01 78 56 34 12, then FC FF ×4, then 04 00 ×4, then 02 with TLAST. Total 25 bytes.
2. **Channel skipping and signed format.** mask=4'b0101, ts_en=0, pkt_len=0, signed=1, ch0=0x2000, ch2=0x0000.
   - Required bytes: A5 00 05 02 00 00 00 80 01(TLAST). Total 9 bytes.
3. **Backpressure.** Scenario 1 with `i_m_axis_tready` randomly toggled.
   - Identical byte sequence; data/last stable whenever tvalid=1 and tready=0; no input accepted outside IDLE/NEXT.
4. **Early flush.** pkt_len=9; feed 3 samples, pulse `i_flush` while in NEXT.
   - Trailer 03 with TLAST.
   - Next packet header seq=01.
   - A flush pulse in IDLE has no effect.
5. **Disabled mask and seq wrap.** mask=0, 5 samples.
   - All accepted, no output bytes, seq unchanged.
   - Then 256 packets: seq runs 00..FF, and the 257th packet carries 00.
6. **Reset mid-packet.** Drop `i_rst_n` during DATA with tvalid=1.
   - tvalid/tlast/busy go to 0 in the same cycle.
   - After release, the next packet starts with A5 00.
